// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Ports:
//   clk        - system clock, rising edge
//   srst       - asynchronous active-high reset, clears all state
//   configure  - register write strobe
//   addr       - register byte address (addr[7:0] decoded)
//   data_in    - write data
//   data_out   - registered read data of the register at addr
//   tx         - serial line out, idle high, registered
//   irq        - FIFO empty, transmitter idle and TXEN set (registered)
// Register map: 0x00 CTRL, 0x04 STATUS, 0x08 DIV, 0x10 TXDATA.
module uart_tx_ctrl #(
    parameter int unsigned DEFAULT_DIV = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned DIV_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        configure,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_DIV    = 8'h08;
    localparam logic [7:0] ADDR_TXDATA = 8'h10;

    logic [1:0]           state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DIV_WIDTH-1:0] timer_q, timer_d;
    logic [DIV_WIDTH-1:0] reload_q, reload_d;
    logic                 tx_q, tx_d;
    logic                 irq_q, irq_d;
    logic                 txen_q, txen_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 ovf_q, ovf_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     count_q, count_d;
    logic [31:0]          data_out_q, data_out_d;
    logic [7:0]           fifo_q [FIFO_DEPTH];

    logic                 fifo_empty_c, fifo_full_c, can_pop_c, pop_c;
    logic                 push_req_c, push_ok_c;
    logic [DIV_WIDTH-1:0] eff_div_m1_c;
    logic                 unused_bits;

    assign unused_bits = ^{addr[31:8], data_in, wr_ptr_q[PTR_W-1], rd_ptr_q[PTR_W-1]};

    assign fifo_empty_c = (count_q == '0);
    assign fifo_full_c  = (count_q == PTR_W'(FIFO_DEPTH));
    assign can_pop_c    = txen_q & ~fifo_empty_c;
    assign push_req_c   = configure & (addr[7:0] == ADDR_TXDATA);
    assign push_ok_c    = push_req_c & (~fifo_full_c | pop_c);

    // Divisors below 2 are clamped to 2; the timer counts divisor-1 down to 0.
    assign eff_div_m1_c = (div_q < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : (div_q - DIV_WIDTH'(1));

    // Transmit FSM next-state, timer and shift register.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        timer_d   = timer_q;
        reload_d  = reload_q;
        pop_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_pop_c) begin
                    pop_c    = 1'b1;
                    shift_d  = fifo_q[rd_ptr_q[AW-1:0]];
                    reload_d = eff_div_m1_c;
                    timer_d  = eff_div_m1_c;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == '0) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    timer_d   = reload_q;
                end else begin
                    timer_d = timer_q - DIV_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    timer_d = reload_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - DIV_WIDTH'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == '0) begin
                    // Chain straight into the next frame when data is waiting.
                    if (can_pop_c) begin
                        pop_c    = 1'b1;
                        shift_d  = fifo_q[rd_ptr_q[AW-1:0]];
                        reload_d = eff_div_m1_c;
                        timer_d  = eff_div_m1_c;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - DIV_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the state being entered so tx changes on the same edge.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            tx_d = shift_d[0];
        end
    end

    // FIFO pointers, occupancy and overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok_c) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : (wr_ptr_q + PTR_W'(1));
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : (rd_ptr_q + PTR_W'(1));
        end
        if (push_ok_c && !pop_c) begin
            count_d = count_q + PTR_W'(1);
        end else if (!push_ok_c && pop_c) begin
            count_d = count_q - PTR_W'(1);
        end
        if (push_req_c && !push_ok_c) begin
            ovf_d = 1'b1;
        end else if (configure && (addr[7:0] == ADDR_STATUS)) begin
            ovf_d = 1'b0;
        end
    end

    // Control register writes, read mux and interrupt.
    always_comb begin
        txen_d = txen_q;
        div_d  = div_q;
        if (configure && (addr[7:0] == ADDR_CTRL)) begin
            txen_d = data_in[0];
        end
        if (configure && (addr[7:0] == ADDR_DIV)) begin
            div_d = data_in[DIV_WIDTH-1:0];
        end
        case (addr[7:0])
            ADDR_CTRL:   data_out_d = {31'd0, txen_q};
            ADDR_STATUS: data_out_d = {28'd0, ovf_q, fifo_empty_c, fifo_full_c,
                                       (state_q != ST_IDLE)};
            ADDR_DIV:    data_out_d = 32'(div_q);
            default:     data_out_d = 32'd0;
        endcase
        irq_d = (state_q == ST_IDLE) & fifo_empty_c & txen_q;
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            timer_q    <= '0;
            reload_q   <= '0;
            tx_q       <= 1'b1;
            irq_q      <= 1'b0;
            txen_q     <= 1'b0;
            div_q      <= DIV_WIDTH'(DEFAULT_DIV);
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            timer_q    <= timer_d;
            reload_q   <= reload_d;
            tx_q       <= tx_d;
            irq_q      <= irq_d;
            txen_q     <= txen_d;
            div_q      <= div_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            if (push_ok_c) begin
                fifo_q[wr_ptr_q[AW-1:0]] <= data_in[7:0];
            end
        end
    end

    assign data_out = data_out_q;
    assign tx       = tx_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl.
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        srst;
    logic        configure;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl dut (
        .clk       (clk),
        .srst      (srst),
        .configure (configure),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // One-cycle register write; returns on the falling edge after the write edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        configure = 1'b1;
        addr      = a;
        data_in   = d;
        @(negedge clk);
        configure = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        configure = 1'b0;
        addr      = a;
        @(negedge clk);
        d = data_out;
    endtask

    // Called on the falling edge before the pop edge; samples the first and last
    // cycle of every bit and returns on the last falling edge of the stop bit.
    task automatic expect_frame(input logic [7:0] b, input int div, input string tag);
        logic [9:0] bits;
        int n;
        bits = {1'b1, b, 1'b0};
        n = 0;
        for (int k = 0; k < 10; k++) begin
            while (n < div * k + 1) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (tx !== bits[k]) begin
                errors++;
                $display("FAIL %s bit%0d first cycle: tx=%b expected %b", tag, k, tx, bits[k]);
            end
            while (n < div * k + div) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (tx !== bits[k]) begin
                errors++;
                $display("FAIL %s bit%0d last cycle: tx=%b expected %b", tag, k, tx, bits[k]);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        srst = 1'b1; configure = 1'b0; addr = '0; data_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++;
        if (data_out !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", data_out); end
        srst = 1'b0;
        rd(32'h04, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected 4", d); end
        rd(32'h08, d);
        checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL reset_div: got %h expected 10", d); end
        rd(32'h00, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        rd(32'h10, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 0", d); end
        rd(32'h0C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
        checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_idle_lines: tx=%b irq=%b expected 1 0", tx, irq);
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] d;
        wr(32'h00, 32'h1);
        wr(32'h08, 32'd16);
        wr(32'h10, 32'h55);
        expect_frame(8'h55, 16, "frame55");
        repeat (2) @(negedge clk);
        rd(32'h04, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL basic_status: got %h expected 4", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b expected 1", irq); end
    endtask

    task automatic test_overflow_back_to_back();
        logic [31:0] d;
        wr(32'h00, 32'h0);
        for (int i = 0; i < 5; i++) begin
            wr(32'h10, 32'h41 + 32'(i));
        end
        rd(32'h04, d);
        checks++;
        if (d !== 32'hA) begin errors++; $display("FAIL ovf_status: got %h expected a", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_txen0: got %b expected 0", irq); end
        wr(32'h00, 32'h1);
        for (int i = 0; i < 4; i++) begin
            expect_frame(8'h41 + 8'(i), 16, "b2b");
        end
        repeat (2) @(negedge clk);
        rd(32'h04, d);
        checks++;
        if (d !== 32'hC) begin errors++; $display("FAIL b2b_status: got %h expected c", d); end
        wr(32'h04, 32'h0);
        rd(32'h04, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL ovf_clear: got %h expected 4", d); end
    endtask

    task automatic test_div_min();
        logic [31:0] d;
        wr(32'h08, 32'h1);
        rd(32'h08, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL div_raw: got %h expected 1", d); end
        wr(32'h10, 32'hA3);
        fork
            expect_frame(8'hA3, 2, "div1");
            begin
                wr(32'h08, 32'd8);
                wr(32'h10, 32'h5C);
            end
        join
        expect_frame(8'h5C, 8, "div8");
        repeat (2) @(negedge clk);
        rd(32'h04, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL div_status: got %h expected 4", d); end
    endtask

    task automatic test_txen_clear();
        logic [31:0] d;
        logic saw_low;
        wr(32'h10, 32'hF0);
        fork
            expect_frame(8'hF0, 8, "txen_off");
            begin
                wr(32'h10, 32'h0F);
                repeat (32) @(negedge clk);
                wr(32'h00, 32'h0);
            end
        join
        saw_low = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low !== 1'b0) begin errors++; $display("FAIL txen_off_idle: tx went low, expected 1"); end
        rd(32'h04, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL txen_off_status: got %h expected 0", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL txen_off_irq: got %b expected 0", irq); end
        wr(32'h00, 32'h1);
        expect_frame(8'h0F, 8, "reenable");
    endtask

    task automatic test_srst_midframe();
        logic [31:0] d;
        wr(32'h10, 32'h00);
        wr(32'h10, 32'h11);
        repeat (20) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL srst_pre_data: got %b expected 0", tx); end
        srst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL srst_tx_immediate: got %b expected 1", tx); end
        repeat (2) @(negedge clk);
        srst = 1'b0;
        rd(32'h04, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL srst_status: got %h expected 4", d); end
        rd(32'h00, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL srst_ctrl: got %h expected 0", d); end
        rd(32'h08, d);
        checks++;
        if (d !== 32'h10) begin errors++; $display("FAIL srst_div: got %h expected 10", d); end
        checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            errors++; $display("FAIL srst_lines: tx=%b irq=%b expected 1 0", tx, irq);
        end
    endtask

    // Behavioural 8N1 receiver sampling mid-bit at divisor 16.
    task automatic test_loopback();
        logic [7:0] rx_byte;
        logic stop_bit;
        int budget;
        wr(32'h00, 32'h1);
        wr(32'h10, 32'h40);
        budget = 0;
        while (tx !== 1'b0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++; $display("FAIL loopback_start: no start bit within %0d cycles", budget);
        end else begin
            repeat (7) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (16) @(negedge clk);
                rx_byte[i] = tx;
            end
            repeat (16) @(negedge clk);
            stop_bit = tx;
            checks++;
            if (rx_byte !== 8'h40) begin errors++; $display("FAIL loopback_data: got %h expected 40", rx_byte); end
            checks++;
            if (stop_bit !== 1'b1) begin errors++; $display("FAIL loopback_stop: got %b expected 1", stop_bit); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow_back_to_back();
        test_div_min();
        test_txen_clear();
        test_srst_midframe();
        test_loopback();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Memory-mapped UART transmitter. It serializes bytes written by the host as 8N1 frames on the `tx` pin.
- It is the sending end of the link that the uart1 receiver samples. Its register interface is the configure/addr/data_in/data_out style used by uart1.
- It sits on the SoC peripheral bus, or is driven directly by a bench task, to feed serial data into the core's `rx`.
- A small TX FIFO decouples host writes from line timing.

Parameters:
- DEFAULT_DIV, 16, reset value of the baud divisor (clock cycles per bit).
- FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- DIV_WIDTH, 16, width of the baud divisor register.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- srst  input  1  reset, asynchronous, active-high; clears all state immediately.
- configure  input  1  write strobe; register write when high at rising edge.
- addr  input  32  register byte address; only addr[7:0] is decoded.
- data_in  input  32  write data.
- data_out  output  32  registered read data of the register at addr (one-cycle read latency).
- tx  output  1  serial line out, idle high, registered.
- irq  output  1  high while FIFO is empty and the transmitter is idle with TXEN=1.

Behaviour:
- Reset values: tx=1, data_out=0, irq=0, CTRL=0, DIV=DEFAULT_DIV, FIFO empty, OVF=0, FSM=IDLE.
- Register map:
  - 0x00 CTRL: bit0 TXEN. Read/write.
  - 0x04 STATUS: bit0 BUSY (FSM not IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky). Writing any value clears OVF.
  - 0x08 DIV: read/write, DIV_WIDTH bits. Effective divisor is max(DIV,2).
  - 0x10 TXDATA: write pushes data_in[7:0] into the FIFO. Reads return 0.
  - Unmapped addresses: writes ignored, reads return 0.
- data_out: updated every rising edge with the register selected by addr at that edge, zero-extended.
- FIFO push on a TXDATA write:
  - Accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and OVF is set.
  - Writes are queued regardless of TXEN.
- Pointer and count width: log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if TXEN=1 and FIFO is not empty, pop the head byte into the shift register, latch the effective divisor into the bit timer, and go to START. tx=1.
  - START: tx=0 for DIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first) for DIV cycles per bit. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for DIV cycles. Then, if TXEN=1 and FIFO is not empty, pop and go directly to START with no extra idle cycle; otherwise go to IDLE.
- Latency: for a write at edge E0 with the FIFO empty, TXEN=1 and FSM in IDLE, the pop occurs at E1 and tx falls after E1. A frame is exactly 10*DIV cycles.
- Clearing TXEN mid-frame: the current frame completes; no further pops.
- A DIV write mid-frame takes effect at the next frame start only.
- Bit timer is a down-counter of DIV_WIDTH bits, loaded with effective divisor−1.
- irq = (FSM==IDLE) & EMPTY & TXEN, registered.
- srst asserted mid-frame: tx returns to 1 immediately, the FIFO is flushed and the partial frame is abandoned.

Test Plan:
- Reset, then read 0x04 and 0x08 -> data_out reads 0x4, then 0x10 (DIV=16); tx=1; irq=0.
- Write CTRL=1, DIV=16, TXDATA=0x55 at edge E0 -> tx falls after E1. Over 160 cycles tx is, per 16-cycle bit: 0,1,0,1,0,1,0,1,0,1. After that the frame is done: BUSY=0 and irq=1.
- With TXEN=0, write 5 bytes 0x41..0x45 at FIFO_DEPTH=4 -> STATUS=0xA (FULL, OVF). Set TXEN -> frames 0x41..0x44 are sent back-to-back with no gap between stop and start. Then EMPTY=1. Writing STATUS clears OVF.
- Write DIV=1, then TXDATA=0xA3 -> bits last 2 cycles each; frame is 20 cycles. A DIV=8 write during that frame does not change it; the next frame uses 8.
- Clear TXEN during bit 3 of 0xF0 with a second byte queued -> the first frame completes, tx stays 1 afterwards and EMPTY=0. Re-enabling starts the second frame one cycle later.
- Assert srst during DATA of 0x00 -> tx=1 in the same cycle, FIFO empty, CTRL=0, DIV=16 after release.
- Loopback with the uart1 receiver configured at matching baud: send "@" -> the receiver data register reads 0x40.
